uart_tx_fifo: RTL and testbench

//  Byte buffer and launch controller feeding the UART Tx FSM. A host writes bytes into a FIFO.

---
 rtl/uart_tx_fifo.sv | 167 ++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
// Byte FIFO plus launch controller in front of the UART Tx FSM. The host
// pushes bytes. Each byte is handed to the Tx FSM with a one-cycle Data_Valid
// pulse, and P_DATA holds that byte. The next byte goes out only after the
// Tx FSM has raised busy and then dropped it again.
//
// Ports
//   CLK        in   system clock, rising edge
//   RST        in   asynchronous reset, active low
//   wr_en      in   host write strobe, one byte per cycle
//   wr_data    in   host write data
//   clr_flags  in   pulse, clears overflow and ack_err
//   busy       in   Tx FSM busy
//   Data_Valid out  one-cycle launch pulse, high while in LAUNCH
//   P_DATA     out  byte being launched, held until the next launch
//   full       out  FIFO holds DEPTH entries
//   empty      out  FIFO holds no entries
//   fifo_count out  entries held, 0..DEPTH
//   overflow   out  sticky, a write was attempted while full
//   ack_err    out  sticky, busy never rose after a launch
module uart_tx_fifo #(
  parameter int DATA_WIDTH  = 8,
  parameter int DEPTH       = 16,
  parameter int ACK_TIMEOUT = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     wr_en,
  input  logic [DATA_WIDTH-1:0]    wr_data,
  input  logic                     clr_flags,
  input  logic                     busy,
  output logic                     Data_Valid,
  output logic [DATA_WIDTH-1:0]    P_DATA,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow,
  output logic                     ack_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(ACK_TIMEOUT);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_ACK  = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]           count_q, count_d;
  logic [DATA_WIDTH-1:0]   p_data_q, p_data_d;
  logic                    overflow_q, overflow_d;
  logic                    ack_err_q, ack_err_d;
  logic [TW-1:0]           timer_q, timer_d;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

  logic push;
  logic pop;
  logic ack_timeout;

  // full/empty come from the registered count, so they reflect the state
  // before any pop in the current cycle. A write while full is always
  // dropped, even when a launch frees a slot in the same cycle.
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign push  = wr_en && !full;
  // The byte leaves the FIFO during the LAUNCH cycle. Its value was already
  // copied into P_DATA when LAUNCH was entered.
  assign pop   = (state_q == LAUNCH);

  always_comb begin
    state_d     = state_q;
    p_data_d    = p_data_q;
    timer_d     = timer_q;
    ack_timeout = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty && !busy) begin
          state_d  = LAUNCH;
          p_data_d = mem_q[rd_ptr_q];
        end
      end
      LAUNCH: begin
        state_d = WAIT_ACK;
        timer_d = '0;
      end
      WAIT_ACK: begin
        if (busy) begin
          state_d = WAIT_DONE;
        end else if (timer_q == TW'(ACK_TIMEOUT - 1)) begin
          // Tx FSM never picked the byte up; drop it and move on.
          state_d     = IDLE;
          ack_timeout = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      WAIT_DONE: begin
        if (!busy) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    // A set event in the same cycle as clr_flags wins.
    overflow_d = (clr_flags ? 1'b0 : overflow_q) | (wr_en & full);
    ack_err_d  = (clr_flags ? 1'b0 : ack_err_q) | ack_timeout;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      p_data_q   <= '0;
      overflow_q <= 1'b0;
      ack_err_q  <= 1'b0;
      timer_q    <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      p_data_q   <= p_data_d;
      overflow_q <= overflow_d;
      ack_err_q  <= ack_err_d;
      timer_q    <= timer_d;
    end
  end

  // Storage is not reset; only the pointers and count define its contents.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  assign Data_Valid = (state_q == LAUNCH);
  assign P_DATA     = p_data_q;
  assign fifo_count = count_q;
  assign overflow   = overflow_q;
  assign ack_err    = ack_err_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed testbench for uart_tx_fifo. A small busy model answers each
// Data_Valid like the Tx FSM would. A monitor records every launched byte.
module tb_uart_tx_fifo;

  logic       CLK = 1'b0;
  logic       RST;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       clr_flags;
  logic       busy;
  logic       Data_Valid;
  logic [7:0] P_DATA;
  logic       full;
  logic       empty;
  logic [4:0] fifo_count;
  logic       overflow;
  logic       ack_err;

  logic       auto_busy;
  logic       busy_model;
  logic       busy_force;

  logic [7:0] launched [$];
  int         dv_busy_err;
  int         n_checks;
  int         n_pass;
  int         n;
  int         errs;
  int         n_launch;

  assign busy = auto_busy ? busy_model : busy_force;

  uart_tx_fifo #(
    .DATA_WIDTH (8),
    .DEPTH      (16),
    .ACK_TIMEOUT(4)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .clr_flags (clr_flags),
    .busy      (busy),
    .Data_Valid(Data_Valid),
    .P_DATA    (P_DATA),
    .full      (full),
    .empty     (empty),
    .fifo_count(fifo_count),
    .overflow  (overflow),
    .ack_err   (ack_err)
  );

  always #5 CLK = ~CLK;

  // Tx FSM model: busy rises one cycle after Data_Valid, stays up 11 cycles.
  initial begin
    busy_model = 1'b0;
    forever begin
      @(negedge CLK);
      if (auto_busy && Data_Valid) begin
        @(posedge CLK);
        #1 busy_model = 1'b1;
        repeat (11) @(posedge CLK);
        #1 busy_model = 1'b0;
      end
    end
  end

  // Launch monitor
  initial begin
    dv_busy_err = 0;
    forever begin
      @(negedge CLK);
      if (Data_Valid === 1'b1) begin
        launched.push_back(P_DATA);
        if (busy) dv_busy_err++;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_dv(output int cycles);
    cycles = 0;
    while (Data_Valid !== 1'b1 && cycles < 10) begin
      tick();
      cycles++;
    end
    if (Data_Valid !== 1'b1) check("dv_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    n_checks   = 0;
    n_pass     = 0;
    auto_busy  = 1'b0;
    busy_force = 1'b0;
    clr_flags  = 1'b0;
    wr_en      = 1'b1;
    wr_data    = 8'h77;
    RST        = 1'b0;

    // 1: reset held with wr_en high
    repeat (3) tick();
    check("rst_empty", empty, 1);
    check("rst_count", fifo_count, 0);
    check("rst_dv", Data_Valid, 0);
    check("rst_pdata", P_DATA, 0);
    check("rst_full", full, 0);
    check("rst_flags", {overflow, ack_err}, 0);
    wr_en = 1'b0;
    RST   = 1'b1;
    tick();
    check("rst_no_push", fifo_count, 0);

    // 2: single byte
    auto_busy = 1'b1;
    wr_en     = 1'b1;
    wr_data   = 8'hA5;
    tick();
    wr_en = 1'b0;
    check("single_count", fifo_count, 1);
    check("single_notempty", empty, 0);
    wait_dv(n);
    // Data_Valid is high from the first edge after the write edge, so the
    // Tx FSM samples it on the second edge.
    check("single_latency", n, 1);
    check("single_pdata", P_DATA, 8'hA5);
    tick();
    check("single_pulse", Data_Valid, 0);
    repeat (20) tick();
    check("single_launches", launched.size(), 1);
    check("single_empty", empty, 1);
    check("single_ackerr", ack_err, 0);

    // 3: ordering over three frames
    wr_en = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      wr_data = 8'(i);
      tick();
    end
    wr_en = 1'b0;
    n = 0;
    while (launched.size() < 4 && n < 300) begin
      tick();
      n++;
    end
    repeat (16) tick();
    check("order_count", launched.size(), 4);
    check("order_b0", launched[1], 8'h01);
    check("order_b1", launched[2], 8'h02);
    check("order_b2", launched[3], 8'h03);
    check("order_pacing", dv_busy_err, 0);

    // 4: fill past full with busy held high
    busy_force = 1'b1;
    auto_busy  = 1'b0;
    wr_en      = 1'b1;
    for (int i = 0; i < 17; i++) begin
      wr_data = 8'h10 + 8'(i);
      tick();
    end
    wr_en = 1'b0;
    check("full_flag", full, 1);
    check("full_count", fifo_count, 16);
    check("full_overflow", overflow, 1);
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    check("ovf_cleared", overflow, 0);
    // write while full coinciding with clr_flags: the set wins
    wr_en     = 1'b1;
    wr_data   = 8'hEE;
    clr_flags = 1'b1;
    tick();
    wr_en     = 1'b0;
    clr_flags = 1'b0;
    check("ovf_set_wins", overflow, 1);
    check("ovf_count", fifo_count, 16);
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    check("ovf_cleared2", overflow, 0);
    busy_force = 1'b0;
    auto_busy  = 1'b1;
    n = 0;
    while (launched.size() < 20 && n < 600) begin
      tick();
      n++;
    end
    repeat (16) tick();
    check("drain_count", launched.size(), 20);
    errs = 0;
    for (int i = 0; i < 16; i++) begin
      if (launched[4 + i] !== 8'h10 + 8'(i)) errs++;
    end
    check("drain_order", errs, 0);
    check("drain_empty", empty, 1);
    check("drain_pacing", dv_busy_err, 0);

    // 5: push during the LAUNCH cycle with five entries held
    busy_force = 1'b1;
    auto_busy  = 1'b0;
    wr_en      = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wr_data = 8'h50 + 8'(i);
      tick();
    end
    wr_en = 1'b0;
    check("simul_pre", fifo_count, 5);
    busy_force = 1'b0;
    tick();
    check("simul_dv", Data_Valid, 1);
    check("simul_pdata", P_DATA, 8'h50);
    check("simul_cnt_launch", fifo_count, 5);
    wr_en      = 1'b1;
    wr_data    = 8'h55;
    busy_force = 1'b1;
    tick();
    wr_en = 1'b0;
    check("simul_count", fifo_count, 5);
    tick();

    // 6: ack timeout, then reset during WAIT_DONE
    busy_force = 1'b0;
    wait_dv(n);
    check("to_pdata", P_DATA, 8'h51);
    check("to_ack_pre", ack_err, 0);
    n = 0;
    while (ack_err !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    // one edge into WAIT_ACK plus four cycles without busy
    check("to_latency", n, 5);
    wait_dv(n);
    check("to_next_pdata", P_DATA, 8'h52);
    check("to_sticky", ack_err, 1);
    clr_flags  = 1'b1;
    busy_force = 1'b1;
    tick();
    clr_flags = 1'b0;
    check("ack_cleared", ack_err, 0);
    tick();
    #2 RST = 1'b0;
    #1;
    check("mid_rst_dv", Data_Valid, 0);
    check("mid_rst_pdata", P_DATA, 0);
    check("mid_rst_count", fifo_count, 0);
    check("mid_rst_empty", empty, 1);
    check("mid_rst_flags", {full, overflow, ack_err}, 0);
    n_launch = launched.size();
    repeat (2) tick();
    RST        = 1'b1;
    busy_force = 1'b0;
    repeat (8) tick();
    check("post_rst_quiet", launched.size(), n_launch);
    wr_en   = 1'b1;
    wr_data = 8'h66;
    tick();
    wr_en = 1'b0;
    wait_dv(n);
    check("post_rst_latency", n, 1);
    check("post_rst_pdata", P_DATA, 8'h66);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
